alu381_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit 74LS381-style ALU. Same 3-bit function select, generalised to WIDTH bits.
- Adds a defined PRESET function, status flags and an accumulator operand source.
- Valid/ready handshake on both input and output sides, 2-stage pipeline with full backpressure.
- Sits between an operand sequencer and a result consumer in the datapath.

---
 rtl/alu381_pipe.sv | 220 ++++++++++++++++++++++
 tb/tb_alu381_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu381_pipe.sv
// -----------------------------------------------------------------------------
// alu381_pipe
//
// Pipelined, parametrised successor to the 4-bit 74LS381-style ALU. It keeps
// the 3-bit function select, widens the datapath to WIDTH bits, and adds a
// PRESET function, status flags (C/Z/N/V) and an accumulator that can replace
// operand A.
//
// Pipeline:
//   stage 1 : operand registers (a, b, sel, use_acc) loaded on input transfer
//   stage 2 : result and flag registers, loaded as stage 1 moves forward
//   Latency is 2 cycles with no stall; throughput is one beat per cycle.
//
// Handshake (both sides): a beat moves on a rising edge where valid && ready.
// A producer holds valid and its payload until it sees ready. The ALU holds
// out_valid and every out_* value steady while out_valid && !out_ready.
// out_ready may be high while out_valid is low. in_ready depends
// combinationally on out_ready, so a full pipe can accept a new beat in the
// same cycle the oldest result leaves.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   in_valid    in   operand beat valid
//   in_ready    out  ALU accepts a beat this cycle
//   in_a        in   operand A            [WIDTH-1:0]
//   in_b        in   operand B            [WIDTH-1:0]
//   in_sel      in   function select      [2:0]
//   in_use_acc  in   1: use the accumulator in place of A at compute time
//   out_valid   out  result valid
//   out_ready   in   consumer accepts result
//   out_f       out  result               [WIDTH-1:0]
//   out_c       out  carry / no-borrow
//   out_z       out  out_f == 0
//   out_n       out  out_f[WIDTH-1]
//   out_v       out  signed overflow (add/subtract only)
//   acc         out  accumulator (newest computed result) [WIDTH-1:0]
// -----------------------------------------------------------------------------
module alu381_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_sel,
    input  logic             in_use_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_f,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n,
    output logic             out_v,
    output logic [WIDTH-1:0] acc
);

    // -------------------------------------------------------------------------
    // Function select encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] SEL_CLEAR  = 3'b000;
    localparam logic [2:0] SEL_B_SUB_A = 3'b001;
    localparam logic [2:0] SEL_A_SUB_B = 3'b010;
    localparam logic [2:0] SEL_ADD    = 3'b011;
    localparam logic [2:0] SEL_XOR    = 3'b100;
    localparam logic [2:0] SEL_OR     = 3'b101;
    localparam logic [2:0] SEL_AND    = 3'b110;
    localparam logic [2:0] SEL_PRESET = 3'b111;

    localparam int MSB = WIDTH - 1;

    // -------------------------------------------------------------------------
    // Stage 1 registers
    // -------------------------------------------------------------------------
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_sel_q;
    logic             s1_use_acc_q;

    // -------------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // -------------------------------------------------------------------------
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_f_q;
    logic             s2_c_q;
    logic             s2_z_q;
    logic             s2_n_q;
    logic             s2_v_q;
    logic [WIDTH-1:0] acc_q;

    // -------------------------------------------------------------------------
    // Pipeline control
    // -------------------------------------------------------------------------
    logic s2_adv;   // stage 2 may load this cycle (empty or being drained)
    logic in_fire;  // input beat transfers on this edge

    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;

    // -------------------------------------------------------------------------
    // Compute: evaluated on the stage-1 contents, captured by stage 2.
    // The accumulator already holds the result of the beat directly ahead,
    // because that beat loaded stage 2 no later than this beat's compute edge.
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] aeff;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] f_d;
    logic             c_d;
    logic             v_d;
    logic             z_d;
    logic             n_d;

    always_comb begin
        aeff  = s1_use_acc_q ? acc_q : s1_a_q;
        sum_d = '0;
        f_d   = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;

        case (s1_sel_q)
            SEL_CLEAR: begin
                f_d = '0;
                c_d = 1'b0;
            end
            SEL_B_SUB_A: begin
                // Two's-complement subtract; carry out set means no borrow.
                sum_d = {1'b0, s1_b_q} + {1'b0, ~aeff} + (WIDTH+1)'(1);
                f_d   = sum_d[WIDTH-1:0];
                c_d   = sum_d[WIDTH];
                v_d   = (s1_b_q[MSB] ^ aeff[MSB]) & (f_d[MSB] ^ s1_b_q[MSB]);
            end
            SEL_A_SUB_B: begin
                sum_d = {1'b0, aeff} + {1'b0, ~s1_b_q} + (WIDTH+1)'(1);
                f_d   = sum_d[WIDTH-1:0];
                c_d   = sum_d[WIDTH];
                v_d   = (aeff[MSB] ^ s1_b_q[MSB]) & (f_d[MSB] ^ aeff[MSB]);
            end
            SEL_ADD: begin
                sum_d = {1'b0, aeff} + {1'b0, s1_b_q};
                f_d   = sum_d[WIDTH-1:0];
                c_d   = sum_d[WIDTH];
                v_d   = ~(aeff[MSB] ^ s1_b_q[MSB]) & (f_d[MSB] ^ aeff[MSB]);
            end
            SEL_XOR: f_d = aeff ^ s1_b_q;
            SEL_OR:  f_d = aeff | s1_b_q;
            SEL_AND: f_d = aeff & s1_b_q;
            SEL_PRESET: f_d = '1;
            default: f_d = '0;
        endcase

        z_d = (f_d == '0);
        n_d = f_d[MSB];
    end

    // -------------------------------------------------------------------------
    // Stage 1: capture a beat on input transfer. Otherwise, when stage 2
    // advances, whatever sat in stage 1 has moved on and stage 1 empties.
    // When stage 2 is stalled and no beat arrives, stage 1 holds.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_sel_q     <= '0;
            s1_use_acc_q <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q   <= 1'b1;
            s1_a_q       <= in_a;
            s1_b_q       <= in_b;
            s1_sel_q     <= in_sel;
            s1_use_acc_q <= in_use_acc;
        end else if (s2_adv) begin
            s1_valid_q   <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: result/flag registers and accumulator. Result registers load
    // only with a real beat, so out_f keeps its last value while empty, and
    // the accumulator only changes when a new result is produced.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_f_q     <= '0;
            s2_c_q     <= 1'b0;
            s2_z_q     <= 1'b0;
            s2_n_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            acc_q      <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_f_q <= f_d;
                s2_c_q <= c_d;
                s2_z_q <= z_d;
                s2_n_q <= n_d;
                s2_v_q <= v_d;
                acc_q  <= f_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid = s2_valid_q;
    assign out_f     = s2_f_q;
    assign out_c     = s2_c_q;
    assign out_z     = s2_z_q;
    assign out_n     = s2_n_q;
    assign out_v     = s2_v_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu381_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu381_pipe
//
// Bench for alu381_pipe at WIDTH=4. Expected results are packed as
// {c, z, n, v, f[3:0]} and pushed to exp_q when a beat is accepted; a monitor
// compares the head of the queue every cycle out_valid is high (so a stalled
// result must stay unchanged) and pops it on output transfer.
// -----------------------------------------------------------------------------
module tb_alu381_pipe;

    localparam int W  = 4;
    localparam int PW = W + 4;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // DUT
    // -------------------------------------------------------------------------
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [2:0]   in_sel = '0;
    logic         in_use_acc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_f;
    logic         out_c, out_z, out_n, out_v;
    logic [W-1:0] acc;

    alu381_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .in_use_acc (in_use_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f),
        .out_c      (out_c),
        .out_z      (out_z),
        .out_n      (out_n),
        .out_v      (out_v),
        .acc        (acc)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [PW-1:0] exp_q[$];
    int            lat_q[$];
    bit            lat_check = 1'b0;
    int            checks = 0;
    int            errors = 0;
    int            n_accepted = 0;
    logic [W-1:0]  m_acc = '0;
    logic [PW-1:0] mon_got;
    int            mon_t;

    function automatic logic [PW-1:0] pack(input logic c, input logic z,
                                           input logic n, input logic v,
                                           input logic [W-1:0] f);
        return {c, z, n, v, f};
    endfunction

    function automatic int sgn(input int x);
        return (x >= 8) ? x - 16 : x;
    endfunction

    // Reference model written in integer arithmetic.
    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] sel, input logic ua);
        int x, y, r, sr;
        logic [W-1:0] f;
        logic c, v;
        x = ua ? int'(m_acc) : int'(a);
        y = int'(b);
        c = 1'b0;
        v = 1'b0;
        f = '0;
        case (sel)
            3'd0: f = '0;
            3'd1: begin
                r = y - x; f = 4'(r); c = (y >= x);
                sr = sgn(y) - sgn(x); v = (sr > 7) || (sr < -8);
            end
            3'd2: begin
                r = x - y; f = 4'(r); c = (x >= y);
                sr = sgn(x) - sgn(y); v = (sr > 7) || (sr < -8);
            end
            3'd3: begin
                r = x + y; f = 4'(r); c = (r > 15);
                sr = sgn(x) + sgn(y); v = (sr > 7) || (sr < -8);
            end
            3'd4: f = 4'(x ^ y);
            3'd5: f = 4'(x | y);
            3'd6: f = 4'(x & y);
            default: f = 4'hF;
        endcase
        return {c, (f == 4'h0), f[W-1], v, f};
    endfunction

    // -------------------------------------------------------------------------
    // Driver: present a beat at negedge, wait (bounded) for in_ready,
    // record the expectation, let the transfer edge pass, drop valid.
    // -------------------------------------------------------------------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic ua,
                        input logic [PW-1:0] exp);
        int waitc = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = sel; in_use_acc = ua;
        #1;
        while (!in_ready && waitc < 200) begin
            @(negedge clk); #1;
            waitc++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1 (a=%b b=%b sel=%b)", in_ready, a, b, sel);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        m_acc = exp[W-1:0];
        n_accepted++;
        if (lat_check) lat_q.push_back(cyc);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            checks++;
            mon_got = {out_c, out_z, out_n, out_v, out_f};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got {c,z,n,v,f}=%b, none expected", mon_got);
            end else begin
                if (mon_got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL result: got {c,z,n,v,f}=%b required %b", mon_got, exp_q[0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (lat_check && lat_q.size() != 0) begin
                        mon_t = lat_q.pop_front();
                        checks++;
                        if (cyc - mon_t != 2) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles required 2", cyc - mon_t);
                        end
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || acc !== 4'h0) begin
            errors++;
            $display("FAIL reset_valid_acc: out_valid=%b acc=%b required 0/0000", out_valid, acc);
        end
        checks++;
        if ({out_c, out_z, out_n, out_v, out_f} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000", {out_c, out_z, out_n, out_v, out_f});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        rst = 1'b0;
        m_acc = '0;
    endtask

    task automatic test_clear_bsuba();
        lat_check = 1'b1;
        send(4'b0011, 4'b1111, 3'b000, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000));
        send(4'b0011, 4'b1111, 3'b001, 1'b0, pack(1'b1, 1'b0, 1'b1, 1'b0, 4'b1100));
        wait_drain("clear_bsuba");
        lat_check = 1'b0;
        lat_q.delete();
        @(negedge clk); #3;
        checks++;
        if (out_valid !== 1'b0 || out_f !== 4'b1100) begin
            errors++;
            $display("FAIL empty_hold: out_valid=%b out_f=%b required 0/1100", out_valid, out_f);
        end
    endtask

    task automatic test_arith();
        send(4'b1111, 4'b0001, 3'b010, 1'b0, pack(1'b1, 1'b0, 1'b1, 1'b0, 4'b1110));
        send(4'b1111, 4'b0001, 3'b011, 1'b0, pack(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000));
        send(4'b0111, 4'b0001, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000));
        send(4'b1000, 4'b0001, 3'b010, 1'b0, pack(1'b1, 1'b0, 1'b0, 1'b1, 4'b0111));
        wait_drain("arith");
    endtask

    task automatic test_logic();
        send(4'b1010, 4'b1100, 3'b100, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0110));
        send(4'b1010, 4'b1100, 3'b101, 1'b0, pack(1'b0, 1'b0, 1'b1, 1'b0, 4'b1110));
        send(4'b1010, 4'b1100, 3'b110, 1'b0, pack(1'b0, 1'b0, 1'b1, 1'b0, 4'b1000));
        send(4'b1010, 4'b1100, 3'b111, 1'b0, pack(1'b0, 1'b0, 1'b1, 1'b0, 4'b1111));
        wait_drain("logic");
    endtask

    task automatic test_acc_chain();
        send(4'b0001, 4'b0010, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011));
        send(4'b0000, 4'b0001, 3'b011, 1'b1, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0100));
        send(4'b0000, 4'b0001, 3'b011, 1'b1, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101));
        send(4'b0000, 4'b0001, 3'b011, 1'b1, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0110));
        wait_drain("acc_chain");
        checks++;
        if (acc !== 4'b0110) begin
            errors++;
            $display("FAIL acc_chain_acc: got %b required 0110", acc);
        end
    endtask

    task automatic test_backpressure();
        int base;
        @(negedge clk);
        out_ready = 1'b0;
        base = n_accepted;
        fork
            begin
                send(4'b0001, 4'b0001, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010));
                send(4'b0010, 4'b0011, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101));
                send(4'b0111, 4'b0111, 3'b100, 1'b0, pack(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000));
                send(4'b0101, 4'b0010, 3'b010, 1'b0, pack(1'b1, 1'b0, 1'b0, 1'b0, 4'b0011));
            end
            begin
                repeat (5) @(negedge clk);
                #3;
                checks++;
                if (in_ready !== 1'b0 || n_accepted - base != 2) begin
                    errors++;
                    $display("FAIL bp_stall: in_ready=%b accepted=%0d required 0/2", in_ready, n_accepted - base);
                end
                checks++;
                if (out_valid !== 1'b1 || acc !== 4'b0010) begin
                    errors++;
                    $display("FAIL bp_hold: out_valid=%b acc=%b required 1/0010", out_valid, acc);
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        checks++;
        if (acc !== 4'b0011) begin
            errors++;
            $display("FAIL bp_acc: got %b required 0011", acc);
        end
    endtask

    task automatic test_reset_midstream();
        send(4'b0001, 4'b0010, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011));
        send(4'b0100, 4'b0100, 3'b011, 1'b0, pack(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000));
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || acc !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b acc=%b required 0/0000", out_valid, acc);
        end
        exp_q.delete();
        lat_q.delete();
        m_acc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(4'b1111, 4'b0101, 3'b011, 1'b1, pack(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101));
        wait_drain("post_reset");
    endtask

    task automatic test_back_to_back_random();
        bit done = 1'b0;
        logic [W-1:0] a, b;
        logic [2:0]   sel;
        logic         ua;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    a   = W'($urandom_range(0, 15));
                    b   = W'($urandom_range(0, 15));
                    sel = 3'($urandom_range(0, 7));
                    ua  = 1'($urandom_range(0, 1));
                    send(a, b, sel, ua, model(a, b, sel, ua));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("random");
        checks++;
        if (acc !== m_acc) begin
            errors++;
            $display("FAIL random_acc: got %b required %b", acc, m_acc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence and report
    // -------------------------------------------------------------------------
    initial begin
        test_reset();
        test_clear_bsuba();
        test_arith();
        test_logic();
        test_acc_chain();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back_random();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
